sram_sp_arb2_be: RTL and testbench

SRAM_SP_ARB2_BE -- requirements
Module: sram_sp_arb2_be

---
 rtl/sram_sp_arb2_be.sv | 143 ++++++++++++++
 tb/tb_sram_sp_arb2_be.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arb2_be.sv
// Single-port byte-enable SRAM shared by two requesters through a
// round-robin arbiter, with in-order per-port responses.
module sram_sp_arb2_be #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    p0_req_i,
   output logic                    p0_gnt_o,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,
   input  logic                    p1_req_i,
   output logic                    p1_gnt_o,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,
   output logic [15:0]             conflict_cnt_o
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  last1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  gnt;
   logic                  sel_we;
   logic [NB-1:0]         sel_be;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [15:0]           cnt;

   logic                  s1_v;
   logic                  s1_port;
   logic                  s1_rd;
   logic [DATA_WIDTH-1:0] s1_data;

   logic                  o_v;
   logic                  o_port;
   logic                  o_rd;
   logic [DATA_WIDTH-1:0] o_data;

   // last1 = 1 means port 0 wins the next contention
   assign gnt0 = !rst && p0_req_i && (!p1_req_i || last1);
   assign gnt1 = !rst && p1_req_i && (!p0_req_i || !last1);
   assign gnt  = gnt0 | gnt1;

   assign p0_gnt_o = gnt0;
   assign p1_gnt_o = gnt1;

   assign sel_we    = gnt1 ? p1_we_i    : p0_we_i;
   assign sel_be    = gnt1 ? p1_be_i    : p0_be_i;
   assign sel_addr  = gnt1 ? p1_addr_i  : p0_addr_i;
   assign sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;

   always_ff @(posedge clk) begin
      if (gnt && sel_we) begin
         for (int i = 0; i < NB; i++) begin
            if (sel_be[i])
               mem[sel_addr][8*i +: 8] <= sel_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (gnt && !sel_we)
         s1_data <= mem[sel_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_port <= 1'b0;
         s1_rd   <= 1'b0;
         last1   <= 1'b1;
         cnt     <= 16'd0;
      end else begin
         s1_v    <= gnt;
         s1_port <= gnt1;
         s1_rd   <= gnt && !sel_we;
         if (gnt)
            last1 <= gnt1;
         if (p0_req_i && p1_req_i && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  r_v;
         logic                  r_port;
         logic                  r_rd;
         logic [DATA_WIDTH-1:0] r_data;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_v    <= 1'b0;
               r_port <= 1'b0;
               r_rd   <= 1'b0;
            end else begin
               r_v    <= s1_v;
               r_port <= s1_port;
               r_rd   <= s1_rd;
            end
         end

         always_ff @(posedge clk) begin
            if (s1_v && s1_rd)
               r_data <= s1_data;
         end

         assign o_v    = r_v;
         assign o_port = r_port;
         assign o_rd   = r_rd;
         assign o_data = r_data;
      end else begin : g_direct
         assign o_v    = s1_v;
         assign o_port = s1_port;
         assign o_rd   = s1_rd;
         assign o_data = s1_data;
      end
   endgenerate

   // Responses are masked while reset is held so nothing pending leaks out
   assign p0_rvalid_o = !rst && o_v && !o_port;
   assign p1_rvalid_o = !rst && o_v && o_port;
   assign p0_rdata_o  = (p0_rvalid_o && o_rd) ? o_data : '0;
   assign p1_rdata_o  = (p1_rvalid_o && o_rd) ? o_data : '0;

   assign conflict_cnt_o = cnt;

endmodule

// File: tb/tb_sram_sp_arb2_be.sv
// Bench for sram_sp_arb2_be: two instances (OUT_REG 0 and 1) driven with
// identical stimulus and checked against a transaction-level model.
module tb_sram_sp_arb2_be;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [12:0] addr;
      logic [31:0] wdata;
   } port_t;

   typedef struct {
      int          due;
      int          port;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   port_t       st [2];

   logic        a_gnt0, a_gnt1, a_rv0, a_rv1;
   logic [31:0] a_rd0, a_rd1;
   logic [15:0] a_cnt;
   logic        b_gnt0, b_gnt1, b_rv0, b_rv1;
   logic [31:0] b_rd0, b_rd1;
   logic [15:0] b_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] mm [int];
   int          last_m = 1;
   logic [15:0] cnt_m = 16'd0;
   resp_t       q0 [$];
   resp_t       q1 [$];

   logic [3:0]   obs_gnt, exp_gnt, obs_rv, exp_rv;
   logic [127:0] obs_rd, exp_rd;
   logic [31:0]  obs_cnt, exp_cnt;

   always #5 clk = ~clk;

   sram_sp_arb2_be #(.OUT_REG(0)) u_a (
      .clk(clk), .rst(rst),
      .p0_req_i(st[0].req), .p0_gnt_o(a_gnt0), .p0_we_i(st[0].we),
      .p0_be_i(st[0].be), .p0_addr_i(st[0].addr),
      .p0_wdata_i(st[0].wdata), .p0_rvalid_o(a_rv0), .p0_rdata_o(a_rd0),
      .p1_req_i(st[1].req), .p1_gnt_o(a_gnt1), .p1_we_i(st[1].we),
      .p1_be_i(st[1].be), .p1_addr_i(st[1].addr),
      .p1_wdata_i(st[1].wdata), .p1_rvalid_o(a_rv1), .p1_rdata_o(a_rd1),
      .conflict_cnt_o(a_cnt)
   );

   sram_sp_arb2_be #(.OUT_REG(1)) u_b (
      .clk(clk), .rst(rst),
      .p0_req_i(st[0].req), .p0_gnt_o(b_gnt0), .p0_we_i(st[0].we),
      .p0_be_i(st[0].be), .p0_addr_i(st[0].addr),
      .p0_wdata_i(st[0].wdata), .p0_rvalid_o(b_rv0), .p0_rdata_o(b_rd0),
      .p1_req_i(st[1].req), .p1_gnt_o(b_gnt1), .p1_we_i(st[1].we),
      .p1_be_i(st[1].be), .p1_addr_i(st[1].addr),
      .p1_wdata_i(st[1].wdata), .p1_rvalid_o(b_rv1), .p1_rdata_o(b_rd1),
      .conflict_cnt_o(b_cnt)
   );

   // One clock of the model: predicts this cycle's outputs, captures the
   // DUT's, then applies the edge.
   task automatic tick();
      int          w;
      resp_t       r;
      logic [31:0] v;
      @(negedge clk);
      w = -1;
      if (!rst) begin
         if (st[0].req && st[1].req) w = 1 - last_m;
         else if (st[0].req) w = 0;
         else if (st[1].req) w = 1;
      end
      exp_gnt = 4'b0;
      if (w >= 0) begin
         exp_gnt[w] = 1'b1;
         exp_gnt[w+2] = 1'b1;
      end
      exp_rv = 4'b0;
      exp_rd = '0;
      if (rst) begin
         q0.delete();
         q1.delete();
      end
      if (q0.size() > 0 && q0[0].due == cyc) begin
         r = q0.pop_front();
         exp_rv[r.port] = 1'b1;
         exp_rd[32*r.port +: 32] = r.data;
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
         r = q1.pop_front();
         exp_rv[r.port+2] = 1'b1;
         exp_rd[32*(r.port+2) +: 32] = r.data;
      end
      exp_cnt = {cnt_m, cnt_m};
      obs_gnt = {b_gnt1, b_gnt0, a_gnt1, a_gnt0};
      obs_rv  = {b_rv1, b_rv0, a_rv1, a_rv0};
      obs_rd  = {b_rd1, b_rd0, a_rd1, a_rd0};
      obs_cnt = {b_cnt, a_cnt};
      if (rst) begin
         cnt_m = 16'd0;
         last_m = 1;
      end else begin
         if (st[0].req && st[1].req && cnt_m != 16'hFFFF)
            cnt_m = cnt_m + 16'd1;
         if (w >= 0) begin
            r.port = w;
            r.data = 32'd0;
            if (st[w].we) begin
               v = mm[int'(st[w].addr)];
               for (int i = 0; i < 4; i++)
                  if (st[w].be[i]) v[8*i +: 8] = st[w].wdata[8*i +: 8];
               mm[int'(st[w].addr)] = v;
            end else begin
               r.data = mm[int'(st[w].addr)];
            end
            r.due = cyc + 1;
            q0.push_back(r);
            r.due = cyc + 2;
            q1.push_back(r);
            last_m = w;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports();
      st[0].req = 1'b0;
      st[1].req = 1'b0;
   endtask

   task automatic set_port(input int p, input logic we, input logic [3:0] be,
                           input logic [12:0] addr, input logic [31:0] wd);
      st[p].req = 1'b1;
      st[p].we = we;
      st[p].be = be;
      st[p].addr = addr;
      st[p].wdata = wd;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st[0].req = 1'($urandom_range(0, 1));
         st[1].req = 1'($urandom_range(0, 1));
         tick();
         n_chk++;
         if (obs_gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_gnt got %b want 0000", obs_gnt);
         end
         n_chk++;
         if (obs_rv !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_rvalid got %b want 0000", obs_rv);
         end
         n_chk++;
         if (obs_rd !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", obs_rd);
         end
         if (i > 0) begin
            n_chk++;
            if (obs_cnt !== 32'd0) begin
               n_fail++;
               $display("FAIL reset_cnt got %h want 0", obs_cnt);
            end
         end
      end
      idle_ports();
      rst = 1'b0;
   endtask

   task automatic test_fill();
      for (int a = 0; a < 34; a++) begin
         idle_ports();
         if (a < 32)
            set_port(a % 2, 1'b1, 4'hF, 13'(a), $urandom);
         tick();
         n_chk++;
         if (obs_gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL fill_gnt got %b want %b", obs_gnt, exp_gnt);
         end
         n_chk++;
         if (obs_rv !== exp_rv) begin
            n_fail++;
            $display("FAIL fill_rvalid got %b want %b", obs_rv, exp_rv);
         end
         n_chk++;
         if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL fill_rdata got %h want %h", obs_rd, exp_rd);
         end
      end
      idle_ports();
   endtask

   task automatic test_write_read();
      set_port(0, 1'b1, 4'hF, 13'h005, 32'hDEADBEEF);
      tick();
      set_port(0, 1'b0, 4'h0, 13'h005, 32'h0);
      tick();
      n_chk++;
      if (obs_rv[0] !== 1'b1 || obs_rd[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_resp got rv=%b rd=%h want rv=1 rd=0",
                  obs_rv[0], obs_rd[31:0]);
      end
      idle_ports();
      tick();
      n_chk++;
      if (obs_rv[0] !== 1'b1 || obs_rd[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_after_wr got rv=%b rd=%h want rv=1 rd=deadbeef",
                  obs_rv[0], obs_rd[31:0]);
      end
      tick();
      n_chk++;
      if (obs_rv !== 4'b0100 || obs_rd[95:64] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_after_wr_oreg got rv=%b rd=%h want 0100 deadbeef",
                  obs_rv, obs_rd[95:64]);
      end
   endtask

   task automatic test_byte_mask();
      set_port(1, 1'b1, 4'hF, 13'h010, 32'h11223344);
      tick();
      set_port(1, 1'b1, 4'b0101, 13'h010, 32'hAABBCCDD);
      tick();
      set_port(1, 1'b0, 4'h0, 13'h010, 32'h0);
      tick();
      idle_ports();
      tick();
      n_chk++;
      if (obs_rv[1] !== 1'b1 || obs_rd[63:32] !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL byte_mask got rv=%b rd=%h want rv=1 rd=11bb33dd",
                  obs_rv[1], obs_rd[63:32]);
      end
      n_chk++;
      if (obs_rd !== exp_rd) begin
         n_fail++;
         $display("FAIL byte_mask_model got %h want %h", obs_rd, exp_rd);
      end
      tick();
   endtask

   task automatic test_contention();
      int na0 = 0;
      int na1 = 0;
      logic [1:0] want;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_port(0, 1'b0, 4'h0, 13'd1, 32'h0);
      set_port(1, 1'b0, 4'h0, 13'd2, 32'h0);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) idle_ports();
         tick();
         na0 += int'(obs_rv[0]);
         na1 += int'(obs_rv[1]);
         if (i < 6) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_chk++;
            if (obs_gnt[1:0] !== want || obs_gnt[3:2] !== want) begin
               n_fail++;
               $display("FAIL rr_gnt[%0d] got %b want %b%b", i, obs_gnt,
                        want, want);
            end
         end
         n_chk++;
         if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL rr_rdata[%0d] got %h want %h", i, obs_rd, exp_rd);
         end
      end
      n_chk++;
      if (a_cnt !== 16'd6 || b_cnt !== 16'd6) begin
         n_fail++;
         $display("FAIL rr_conflict_cnt got %0d/%0d want 6", a_cnt, b_cnt);
      end
      n_chk++;
      if (na0 != 3 || na1 != 3) begin
         n_fail++;
         $display("FAIL rr_resp_count got %0d/%0d want 3/3", na0, na1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         idle_ports();
         if (k < 4) set_port(1, 1'b0, 4'h0, 13'(20 + k), 32'h0);
         tick();
         n_chk++;
         if (obs_rv[3] !== (k >= 2) || obs_rv[1] !== (k >= 1 && k <= 4)) begin
            n_fail++;
            $display("FAIL b2b_timing[%0d] got rv=%b want b=%0d a=%0d", k,
                     obs_rv, (k >= 2), (k >= 1 && k <= 4));
         end
         n_chk++;
         if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL b2b_rdata[%0d] got %h want %h", k, obs_rd, exp_rd);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (!st[p].req && $urandom_range(0, 9) < 7)
               set_port(p, 1'($urandom_range(0, 1)), 4'($urandom),
                        13'($urandom_range(0, 31)), $urandom);
         end
         tick();
         n_chk++;
         if (obs_gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL rand_gnt[%0d] got %b want %b", k, obs_gnt, exp_gnt);
         end
         n_chk++;
         if (obs_rv !== exp_rv) begin
            n_fail++;
            $display("FAIL rand_rvalid[%0d] got %b want %b", k, obs_rv, exp_rv);
         end
         n_chk++;
         if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL rand_rdata[%0d] got %h want %h", k, obs_rd, exp_rd);
         end
         n_chk++;
         if (obs_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL rand_cnt[%0d] got %h want %h", k, obs_cnt, exp_cnt);
         end
         for (int p = 0; p < 2; p++)
            if (exp_gnt[p]) st[p].req = 1'b0;
      end
      idle_ports();
      tick();
      tick();
   endtask

   task automatic test_reset_drop();
      set_port(0, 1'b0, 4'h0, 13'd3, 32'h0);
      tick();
      idle_ports();
      rst = 1'b1;
      tick();
      n_chk++;
      if (obs_rv !== 4'b0 || obs_rd !== '0) begin
         n_fail++;
         $display("FAIL drop_in_rst got rv=%b want 0000", obs_rv);
      end
      rst = 1'b0;
      tick();
      n_chk++;
      if (obs_rv !== 4'b0) begin
         n_fail++;
         $display("FAIL drop_after_rst got rv=%b want 0000", obs_rv);
      end
      set_port(0, 1'b0, 4'h0, 13'd4, 32'h0);
      set_port(1, 1'b0, 4'h0, 13'd5, 32'h0);
      tick();
      n_chk++;
      if (obs_gnt !== 4'b0101) begin
         n_fail++;
         $display("FAIL post_rst_winner got %b want 0101", obs_gnt);
      end
      idle_ports();
      tick();
      n_chk++;
      if (obs_rd !== exp_rd || obs_rv !== exp_rv) begin
         n_fail++;
         $display("FAIL post_rst_resp got %b %h want %b %h", obs_rv, obs_rd,
                  exp_rv, exp_rd);
      end
      tick();
      tick();
   endtask

   task automatic test_saturate();
      set_port(0, 1'b0, 4'h0, 13'd0, 32'h0);
      set_port(1, 1'b0, 4'h0, 13'd1, 32'h0);
      repeat (70000) @(posedge clk);
      cnt_m = (int'(cnt_m) + 70000 > 65535) ? 16'hFFFF : cnt_m + 16'(70000);
      idle_ports();
      q0.delete();
      q1.delete();
      @(negedge clk);
      n_chk++;
      if (a_cnt !== cnt_m || b_cnt !== cnt_m) begin
         n_fail++;
         $display("FAIL saturate got %h/%h want %h", a_cnt, b_cnt, cnt_m);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      n_chk++;
      if (obs_cnt !== exp_cnt || obs_gnt !== 4'b0) begin
         n_fail++;
         $display("FAIL saturate_hold got %h want %h", obs_cnt, exp_cnt);
      end
      rst = 1'b0;
      tick();
      n_chk++;
      if (obs_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL saturate_clear got %h want 0", obs_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      st[0] = '0;
      st[1] = '0;
      test_reset();
      test_fill();
      test_write_read();
      test_byte_mask();
      test_contention();
      test_back_to_back();
      test_random();
      test_reset_drop();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
